// File: rtl/pick_pkg.sv
// rtl/pick_pkg.sv - shared dir codes, HID key codes and state types for the pick cursor path
package pick_pkg;

  localparam logic [2:0] DIR_STOP = 3'b000;
  localparam logic [2:0] DIR_UP1  = 3'b001;
  localparam logic [2:0] DIR_DN1  = 3'b010;
  localparam logic [2:0] DIR_DN2  = 3'b011;
  localparam logic [2:0] DIR_UP2  = 3'b100;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_S = 8'h16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UP_SLOW = 3'd1,
    ST_DN_SLOW = 3'd2,
    ST_DN_FAST = 3'd3,
    ST_UP_FAST = 3'd4
  } pick_dir_state_t;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_UP   = 2'd1,
    REQ_DN   = 2'd2
  } pick_req_t;

  function automatic logic [2:0] dir_of_state(input pick_dir_state_t s);
    logic [2:0] d;
    d = DIR_STOP;
    case (s)
      ST_UP_SLOW: d = DIR_UP1;
      ST_DN_SLOW: d = DIR_DN1;
      ST_DN_FAST: d = DIR_DN2;
      ST_UP_FAST: d = DIR_UP2;
      default:    d = DIR_STOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pick_key_match.sv
// rtl/pick_key_match.sv - resolves two HID keycode slots and pick mode into one motion request
module pick_key_match
  import pick_pkg::*;
#(
  parameter logic [7:0] KEY_UP   = KEY_W,
  parameter logic [7:0] KEY_DOWN = KEY_S
) (
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic       pick_mode,
  output pick_req_t  req
);

  logic up_req;
  logic dn_req;

  assign up_req = (keycode0 == KEY_UP)   || (keycode1 == KEY_UP);
  assign dn_req = (keycode0 == KEY_DOWN) || (keycode1 == KEY_DOWN);

  // Opposing keys cancel rather than picking a winner.
  always_comb begin
    req = REQ_NONE;
    if (pick_mode && (up_req != dn_req)) begin
      req = up_req ? REQ_UP : REQ_DN;
    end
  end

endmodule

// File: rtl/pick_dir_ctrl.sv
// rtl/pick_dir_ctrl.sv - keycode to pick dir command with hold-to-accelerate
module pick_dir_ctrl
  import pick_pkg::*;
#(
  parameter logic [7:0] KEY_UP      = KEY_W,
  parameter logic [7:0] KEY_DOWN    = KEY_S,
  parameter int         HOLD_FRAMES = 30,
  parameter int         CNT_W       = 6
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       pickMode,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [2:0] dir,
  output logic       fast
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_FRAMES - 1);

  pick_req_t       req;
  pick_dir_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]      dir_q, dir_d;
  logic            fast_q, fast_d;

  pick_key_match #(
    .KEY_UP   (KEY_UP),
    .KEY_DOWN (KEY_DOWN)
  ) u_key_match (
    .keycode0  (keycode0),
    .keycode1  (keycode1),
    .pick_mode (pickMode),
    .req       (req)
  );

  // A reversal or release from any moving state restarts the hold count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_UP_SLOW, ST_DN_SLOW: begin
        if ((req == REQ_UP && state_q == ST_UP_SLOW) ||
            (req == REQ_DN && state_q == ST_DN_SLOW)) begin
          if (cnt_q == CNT_MAX) begin
            state_d = (state_q == ST_UP_SLOW) ? ST_UP_FAST : ST_DN_FAST;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (req == REQ_UP) begin
          state_d = ST_UP_SLOW;
          cnt_d   = '0;
        end else if (req == REQ_DN) begin
          state_d = ST_DN_SLOW;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_UP_FAST, ST_DN_FAST: begin
        if ((req == REQ_UP && state_q == ST_UP_FAST) ||
            (req == REQ_DN && state_q == ST_DN_FAST)) begin
          state_d = state_q;
        end else if (req == REQ_UP) begin
          state_d = ST_UP_SLOW;
          cnt_d   = '0;
        end else if (req == REQ_DN) begin
          state_d = ST_DN_SLOW;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        cnt_d = '0;
        if (req == REQ_UP) begin
          state_d = ST_UP_SLOW;
        end else if (req == REQ_DN) begin
          state_d = ST_DN_SLOW;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
    dir_d  = dir_of_state(state_d);
    fast_d = (state_d == ST_UP_FAST) || (state_d == ST_DN_FAST);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= DIR_STOP;
      fast_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      fast_q  <= fast_d;
    end
  end

  assign dir  = dir_q;
  assign fast = fast_q;

endmodule

// File: tb/tb_pick_dir_ctrl.sv
// tb/tb_pick_dir_ctrl.sv - directed self-checking bench for pick_dir_ctrl
module tb_pick_dir_ctrl;

  logic       frame_clk;
  logic       Reset;
  logic       pickMode;
  logic [7:0] keycode0;
  logic [7:0] keycode1;
  logic [2:0] dir;
  logic       fast;
  logic [2:0] dir1;
  logic       fast1;

  int n_total;
  int n_pass;

  pick_dir_ctrl #(.HOLD_FRAMES(4), .CNT_W(6)) dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .pickMode  (pickMode),
    .keycode0  (keycode0),
    .keycode1  (keycode1),
    .dir       (dir),
    .fast      (fast)
  );

  pick_dir_ctrl #(.HOLD_FRAMES(1), .CNT_W(1)) dut1 (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .pickMode  (pickMode),
    .keycode0  (keycode0),
    .keycode1  (keycode1),
    .dir       (dir1),
    .fast      (fast1)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  task automatic step(input logic rst, input logic pm, input logic [7:0] k0, input logic [7:0] k1);
    Reset    = rst;
    pickMode = pm;
    keycode0 = k0;
    keycode1 = k1;
    @(posedge frame_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] de, input logic fe);
    n_total++;
    assert (dir === de) n_pass++;
    else $error("FAIL %s dir got %b want %b", tag, dir, de);
    n_total++;
    assert (fast === fe) n_pass++;
    else $error("FAIL %s fast got %b want %b", tag, fast, fe);
  endtask

  task automatic chk1(input string tag, input logic [2:0] de, input logic fe);
    n_total++;
    assert (dir1 === de && fast1 === fe) n_pass++;
    else $error("FAIL %s h1 dir/fast got %b/%b want %b/%b", tag, dir1, fast1, de, fe);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    Reset = 1'b1; pickMode = 1'b1; keycode0 = 8'h00; keycode1 = 8'h00;

    step(1, 1, 8'h1A, 8'h00); chk("rst0", 3'b000, 0);
    step(1, 1, 8'h1A, 8'h00); chk("rst1", 3'b000, 0);
    step(0, 1, 8'h1A, 8'h00); chk("rst_rel", 3'b001, 0);
    step(0, 1, 8'h00, 8'h00); chk("idle_a", 3'b000, 0);

    for (int i = 0; i < 10; i++) begin
      step(0, 1, 8'h1A, 8'h00);
      chk("up_hold", (i < 4) ? 3'b001 : 3'b100, (i >= 4));
    end
    step(0, 1, 8'h00, 8'h00); chk("up_rel", 3'b000, 0);

    for (int i = 0; i < 6; i++) begin
      step(0, 1, 8'h00, 8'h16);
      chk("dn_hold", (i < 4) ? 3'b010 : 3'b011, (i >= 4));
    end
    step(0, 1, 8'h1A, 8'h00); chk("reversal", 3'b001, 0);
    step(0, 1, 8'h00, 8'h00); chk("idle_b", 3'b000, 0);

    step(0, 1, 8'h1A, 8'h16); chk("both", 3'b000, 0);
    step(0, 1, 8'h1A, 8'h00); chk("drop_dn0", 3'b001, 0);
    step(0, 1, 8'h1A, 8'h00); chk("drop_dn1", 3'b001, 0);
    step(0, 1, 8'h1A, 8'h00); chk("drop_dn2", 3'b001, 0);
    step(0, 1, 8'h1A, 8'h00); chk("drop_dn3", 3'b001, 0);
    step(0, 1, 8'h1A, 8'h00); chk("drop_dn4", 3'b100, 1);
    step(0, 1, 8'h1A, 8'h16); chk("both_fast", 3'b000, 0);
    step(0, 1, 8'h00, 8'h00); chk("idle_c", 3'b000, 0);

    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h16, 8'h00);
      chk("dn_pre", (i < 4) ? 3'b010 : 3'b011, (i >= 4));
    end
    step(0, 0, 8'h16, 8'h00); chk("pm_off", 3'b000, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 8'h16, 8'h00);
      chk("pm_back", (i < 4) ? 3'b010 : 3'b011, (i >= 4));
    end
    step(0, 1, 8'h00, 8'h00); chk("idle_d", 3'b000, 0);

    step(0, 1, 8'h04, 8'h00); chk("unrel0", 3'b000, 0);
    step(0, 1, 8'h04, 8'h00); chk("unrel1", 3'b000, 0);
    step(0, 1, 8'h1A, 8'h04); chk("slot0_a", 3'b001, 0);
    step(0, 1, 8'h1A, 8'h04); chk("slot0_b", 3'b001, 0);
    step(0, 1, 8'h04, 8'h1A); chk("slot1_a", 3'b001, 0);
    step(0, 1, 8'h00, 8'h1A); chk("slot1_b", 3'b001, 0);
    step(0, 1, 8'h00, 8'h1A); chk("slot1_fast", 3'b100, 1);

    step(1, 1, 8'h00, 8'h1A); chk("rst_mid", 3'b000, 0);
    step(0, 1, 8'h00, 8'h1A); chk("rst_restart", 3'b001, 0);

    step(0, 1, 8'h00, 8'h00); chk("idle_e", 3'b000, 0);
    chk1("h1_idle", 3'b000, 0);
    step(0, 1, 8'h16, 8'h00); chk1("h1_slow", 3'b010, 0);
    step(0, 1, 8'h16, 8'h00); chk1("h1_fast", 3'b011, 1);
    step(0, 1, 8'h1A, 8'h00); chk1("h1_rev", 3'b001, 0);
    step(0, 1, 8'h1A, 8'h00); chk1("h1_upfast", 3'b100, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
